// File: rtl/two_three_demux.sv
// Registered 2-lane to 3-output demultiplexer with valid/ready on both sides.
// Lane 1 wins collisions; destination 3 discards the word and bumps DROPS.
`timescale 1ns/1ps
module two_three_demux #(
    parameter int W     = 2,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [W-1:0]     I1,
    input  logic [1:0]       D1,
    input  logic             V1,
    output logic             R1,
    input  logic [W-1:0]     I2,
    input  logic [1:0]       D2,
    input  logic             V2,
    output logic             R2,
    output logic [W-1:0]     X,
    output logic [W-1:0]     Y,
    output logic [W-1:0]     Z,
    output logic             XV,
    output logic             YV,
    output logic             ZV,
    input  logic             XR,
    input  logic             YR,
    input  logic             ZR,
    output logic [CNT_W-1:0] DROPS
);

    logic [2:0]     vld;
    logic [2:0]     rdy;
    logic [W-1:0]   data [3];
    logic [3:0]     free;
    logic [3:0]     ld1;
    logic [3:0]     ld2;
    logic [1:0]     inc;
    logic [CNT_W:0] sum;

    assign rdy  = {ZR, YR, XR};
    // Index 3 is the drop sink, which can always accept.
    assign free = {1'b1, ~vld | rdy};

    assign R1 = free[D1];
    assign R2 = free[D2] & ~(V1 & (D1 == D2) & (D2 != 2'd3));

    assign ld1 = (V1 & R1) ? (4'b0001 << D1) : 4'b0000;
    assign ld2 = (V2 & R2) ? (4'b0001 << D2) : 4'b0000;

    assign inc = {1'b0, ld1[3]} + {1'b0, ld2[3]};
    assign sum = {1'b0, DROPS} + {{(CNT_W-1){1'b0}}, inc};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld   <= '0;
            DROPS <= '0;
            for (int k = 0; k < 3; k++) data[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (ld1[k]) begin
                    data[k] <= I1;
                    vld[k]  <= 1'b1;
                end else if (ld2[k]) begin
                    data[k] <= I2;
                    vld[k]  <= 1'b1;
                end else if (rdy[k]) begin
                    vld[k]  <= 1'b0;
                end
            end
            DROPS <= sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    assign X  = data[0];
    assign Y  = data[1];
    assign Z  = data[2];
    assign XV = vld[0];
    assign YV = vld[1];
    assign ZV = vld[2];

endmodule

// File: tb/tb_two_three_demux.sv
// Bench for two_three_demux: per-scenario tasks plus a queue scoreboard
// that tracks every accepted word and the saturating drop count.
`timescale 1ns/1ps
module tb_two_three_demux;

    localparam int W     = 2;
    localparam int CNT_W = 8;
    localparam int MAXD  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [W-1:0]     I1 = '0;
    logic [1:0]       D1 = '0;
    logic             V1 = 1'b0;
    logic             R1;
    logic [W-1:0]     I2 = '0;
    logic [1:0]       D2 = '0;
    logic             V2 = 1'b0;
    logic             R2;
    logic [W-1:0]     X, Y, Z;
    logic             XV, YV, ZV;
    logic             XR = 1'b1;
    logic             YR = 1'b1;
    logic             ZR = 1'b1;
    logic [CNT_W-1:0] DROPS;

    int compared   = 0;
    int mismatched = 0;
    int exp_drops  = 0;
    logic [W-1:0] q_x[$];
    logic [W-1:0] q_y[$];
    logic [W-1:0] q_z[$];

    two_three_demux #(.W(W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .I1(I1), .D1(D1), .V1(V1), .R1(R1),
        .I2(I2), .D2(D2), .V2(V2), .R2(R2),
        .X(X), .Y(Y), .Z(Z),
        .XV(XV), .YV(YV), .ZV(ZV),
        .XR(XR), .YR(YR), .ZR(ZR),
        .DROPS(DROPS)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drains are popped before new loads are pushed: a word accepted
    // this cycle only becomes visible after the coming edge.
    task automatic monitor();
        logic [W-1:0] w;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                q_x.delete();
                q_y.delete();
                q_z.delete();
                exp_drops = 0;
            end else begin
                compared++;
                if (DROPS !== CNT_W'(exp_drops)) begin
                    mismatched++;
                    $display("FAIL sb_drops: got %0d, required %0d", DROPS, exp_drops);
                end
                if (XV && XR) begin
                    compared++;
                    if (q_x.size() == 0) begin
                        mismatched++;
                        $display("FAIL sb_x: got word %0d, required none", X);
                    end else begin
                        w = q_x.pop_front();
                        if (X !== w) begin
                            mismatched++;
                            $display("FAIL sb_x: got %0d, required %0d", X, w);
                        end
                    end
                end
                if (YV && YR) begin
                    compared++;
                    if (q_y.size() == 0) begin
                        mismatched++;
                        $display("FAIL sb_y: got word %0d, required none", Y);
                    end else begin
                        w = q_y.pop_front();
                        if (Y !== w) begin
                            mismatched++;
                            $display("FAIL sb_y: got %0d, required %0d", Y, w);
                        end
                    end
                end
                if (ZV && ZR) begin
                    compared++;
                    if (q_z.size() == 0) begin
                        mismatched++;
                        $display("FAIL sb_z: got word %0d, required none", Z);
                    end else begin
                        w = q_z.pop_front();
                        if (Z !== w) begin
                            mismatched++;
                            $display("FAIL sb_z: got %0d, required %0d", Z, w);
                        end
                    end
                end
                if (V1 && R1) begin
                    case (D1)
                        2'd0:    q_x.push_back(I1);
                        2'd1:    q_y.push_back(I1);
                        2'd2:    q_z.push_back(I1);
                        default: exp_drops++;
                    endcase
                end
                if (V2 && R2) begin
                    case (D2)
                        2'd0:    q_x.push_back(I2);
                        2'd1:    q_y.push_back(I2);
                        2'd2:    q_z.push_back(I2);
                        default: exp_drops++;
                    endcase
                end
                if (exp_drops > MAXD) exp_drops = MAXD;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        compared++;
        if ({X, Y, Z, XV, YV, ZV, DROPS} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got %h, required 0", {X, Y, Z, XV, YV, ZV, DROPS});
        end
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_basic_route();
        XR = 1; YR = 1; ZR = 1;
        V1 = 1; I1 = 2'd3; D1 = 2'd2;
        #1;
        compared++;
        if (R1 !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_r1: got %b, required 1", R1);
        end
        tick();
        V1 = 0;
        compared++;
        if (Z !== 2'd3 || ZV !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_load: got Z=%0d ZV=%b, required Z=3 ZV=1", Z, ZV);
        end
        tick();
        compared++;
        if (ZV !== 1'b0 || Z !== 2'd3) begin
            mismatched++;
            $display("FAIL basic_drain: got Z=%0d ZV=%b, required Z=3 ZV=0", Z, ZV);
        end
    endtask

    task automatic test_collision();
        XR = 1;
        V1 = 1; D1 = 2'd0; I1 = 2'd1;
        V2 = 1; D2 = 2'd0; I2 = 2'd2;
        #1;
        compared++;
        if (R1 !== 1'b1 || R2 !== 1'b0) begin
            mismatched++;
            $display("FAIL coll_ready: got R1=%b R2=%b, required R1=1 R2=0", R1, R2);
        end
        tick();
        V1 = 0;
        #1;
        compared++;
        if (X !== 2'd1 || XV !== 1'b1 || R2 !== 1'b1) begin
            mismatched++;
            $display("FAIL coll_first: got X=%0d XV=%b R2=%b, required X=1 XV=1 R2=1", X, XV, R2);
        end
        tick();
        V2 = 0;
        compared++;
        if (X !== 2'd2 || XV !== 1'b1) begin
            mismatched++;
            $display("FAIL coll_second: got X=%0d XV=%b, required X=2 XV=1", X, XV);
        end
        tick();
    endtask

    task automatic test_backpressure();
        XR = 0; YR = 0;
        V1 = 1; D1 = 2'd1; I1 = 2'd1;
        tick();
        compared++;
        if (Y !== 2'd1 || YV !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_fill: got Y=%0d YV=%b, required Y=1 YV=1", Y, YV);
        end
        I1 = 2'd2;
        V2 = 1; D2 = 2'd0; I2 = 2'd3;
        #1;
        compared++;
        if (R1 !== 1'b0 || R2 !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_ready: got R1=%b R2=%b, required R1=0 R2=1", R1, R2);
        end
        tick();
        V2 = 0;
        compared++;
        if (Y !== 2'd1 || YV !== 1'b1 || X !== 2'd3 || XV !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_hold: got Y=%0d YV=%b X=%0d XV=%b, required 1 1 3 1", Y, YV, X, XV);
        end
        YR = 1;
        #1;
        compared++;
        if (R1 !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release: got R1=%b, required 1", R1);
        end
        tick();
        V1 = 0;
        compared++;
        if (Y !== 2'd2 || YV !== 1'b1 || XV !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_reload: got Y=%0d YV=%b XV=%b, required Y=2 YV=1 XV=1", Y, YV, XV);
        end
        XR = 1;
        tick();
        compared++;
        if (XV !== 1'b0 || YV !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_drain: got XV=%b YV=%b, required 0 0", XV, YV);
        end
    endtask

    task automatic test_dual_parallel();
        XR = 1; YR = 1;
        V1 = 1; D1 = 2'd0; I1 = 2'd3;
        V2 = 1; D2 = 2'd1; I2 = 2'd1;
        #1;
        compared++;
        if (R1 !== 1'b1 || R2 !== 1'b1) begin
            mismatched++;
            $display("FAIL dual_ready: got R1=%b R2=%b, required 1 1", R1, R2);
        end
        tick();
        V1 = 0; V2 = 0;
        compared++;
        if (X !== 2'd3 || Y !== 2'd1 || XV !== 1'b1 || YV !== 1'b1) begin
            mismatched++;
            $display("FAIL dual_load: got X=%0d Y=%0d XV=%b YV=%b, required 3 1 1 1", X, Y, XV, YV);
        end
        tick();
    endtask

    task automatic test_invalid_lane();
        XR = 0;
        V2 = 1; D2 = 2'd0; I2 = 2'd1;
        tick();
        V2 = 0;
        V1 = 0; D1 = 2'd0;
        #1;
        compared++;
        if (R1 !== 1'b0) begin
            mismatched++;
            $display("FAIL inv_r1_full: got %b, required 0", R1);
        end
        D1 = 2'd2; D2 = 2'd2;
        #1;
        compared++;
        if (R2 !== 1'b1) begin
            mismatched++;
            $display("FAIL inv_no_collide: got R2=%b, required 1", R2);
        end
        XR = 1;
        tick();
    endtask

    task automatic test_reset_midrun();
        XR = 0;
        V1 = 1; D1 = 2'd3;
        repeat (5) tick();
        D1 = 2'd0; I1 = 2'd2;
        tick();
        V1 = 0;
        compared++;
        if (DROPS !== 8'd5 || XV !== 1'b1 || X !== 2'd2) begin
            mismatched++;
            $display("FAIL mid_pre: got DROPS=%0d XV=%b X=%0d, required 5 1 2", DROPS, XV, X);
        end
        RST_N = 0;
        #1;
        compared++;
        if ({X, Y, Z, XV, YV, ZV, DROPS} !== '0) begin
            mismatched++;
            $display("FAIL mid_reset: got %h, required 0", {X, Y, Z, XV, YV, ZV, DROPS});
        end
        YR = 0;
        V1 = 1; D1 = 2'd1; I1 = 2'd2;
        tick();
        compared++;
        if (YV !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_no_load: got YV=%b, required 0", YV);
        end
        RST_N = 1;
        tick();
        V1 = 0;
        compared++;
        if (YV !== 1'b1 || Y !== 2'd2) begin
            mismatched++;
            $display("FAIL mid_first_load: got Y=%0d YV=%b, required 2 1", Y, YV);
        end
        XR = 1; YR = 1;
        tick();
    endtask

    task automatic test_drops();
        V1 = 1; D1 = 2'd3;
        V2 = 1; D2 = 2'd3;
        for (int i = 0; i < 200; i++) begin
            compared++;
            if (R1 !== 1'b1 || R2 !== 1'b1) begin
                mismatched++;
                $display("FAIL drop_ready[%0d]: got R1=%b R2=%b, required 1 1", i, R1, R2);
            end
            tick();
            if (i == 9) begin
                compared++;
                if (DROPS !== 8'd20) begin
                    mismatched++;
                    $display("FAIL drop_count: got %0d, required 20", DROPS);
                end
            end
        end
        V1 = 0; V2 = 0;
        compared++;
        if (DROPS !== 8'd255) begin
            mismatched++;
            $display("FAIL drop_sat: got %0d, required 255", DROPS);
        end
        tick();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic_route();
        test_collision();
        test_backpressure();
        test_dual_parallel();
        test_invalid_lane();
        test_reset_midrun();
        test_drops();
        XR = 1; YR = 1; ZR = 1;
        repeat (3) tick();
        compared++;
        if (q_x.size() + q_y.size() + q_z.size() != 0) begin
            mismatched++;
            $display("FAIL sb_leftover: got %0d words, required 0",
                     q_x.size() + q_y.size() + q_z.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
